// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter port bundle: per-unit request/tag/grant plus the
// registered CDB broadcast controls and divider occupancy.
interface cdb_arbiter_if #(
  parameter int TAG_W = 6
);
  logic             req_int;
  logic             req_ld;
  logic             req_mult;
  logic             req_div;
  logic [TAG_W-1:0] tag_int;
  logic [TAG_W-1:0] tag_ld;
  logic [TAG_W-1:0] tag_mult;
  logic [TAG_W-1:0] tag_div;
  logic             gnt_int;
  logic             gnt_ld;
  logic             gnt_mult;
  logic             gnt_div;
  logic             cdb_valid;
  logic [3:0]       cdb_sel;
  logic [TAG_W-1:0] cdb_tag;
  logic             div_busy;

  // Issue-queue / execution-unit side.
  modport master (
    output req_int, req_ld, req_mult, req_div,
    output tag_int, tag_ld, tag_mult, tag_div,
    input  gnt_int, gnt_ld, gnt_mult, gnt_div,
    input  cdb_valid, cdb_sel, cdb_tag, div_busy
  );

  // Arbiter side.
  modport slave (
    input  req_int, req_ld, req_mult, req_div,
    input  tag_int, tag_ld, tag_mult, tag_div,
    output gnt_int, gnt_ld, gnt_mult, gnt_div,
    output cdb_valid, cdb_sel, cdb_tag, div_busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB writeback scheduler. Every grant reserves the future CDB slot its result
// will land in, using a shift pipeline of owner-tagged reservations; slot 0 is
// the registered broadcast (cdb_valid/cdb_sel/cdb_tag).
// Unit latencies: int = 1, ld = 1, mult = MULT_LAT, div = DIV_LAT.
module cdb_arbiter #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7,
  parameter int TAG_W    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  cdb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    U_INT  = 2'd0,
    U_LD   = 2'd1,
    U_MULT = 2'd2,
    U_DIV  = 2'd3
  } unit_e;

  typedef struct packed {
    logic             v;
    unit_e            unit;
    logic [TAG_W-1:0] tag;
  } slot_t;

  // s_q[k] is the broadcast planned k cycles from now.
  slot_t            s_q [1:DIV_LAT];
  slot_t            s_d [1:DIV_LAT];
  slot_t            slot0_d;

  logic             lru_q, lru_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_busy_q, div_busy_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [3:0]       cdb_sel_q, cdb_sel_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;

  logic             gnt_int, gnt_ld, gnt_mult, gnt_div;
  logic             slot1_free;

  // Grant decisions from current state; int and ld share slot 1, LRU breaks ties.
  always_comb begin
    gnt_div    = reset_n & bus.req_div & ~div_busy_q;
    gnt_mult   = reset_n & bus.req_mult & ~s_q[MULT_LAT].v;
    slot1_free = reset_n & ~s_q[1].v;
    gnt_int    = 1'b0;
    gnt_ld     = 1'b0;
    lru_d      = lru_q;
    if (slot1_free) begin
      if (bus.req_int && bus.req_ld) begin
        if (lru_q) begin
          gnt_ld = 1'b1;
          lru_d  = 1'b0;
        end else begin
          gnt_int = 1'b1;
          lru_d   = 1'b1;
        end
      end else begin
        gnt_int = bus.req_int;
        gnt_ld  = bus.req_ld;
      end
    end
  end

  // Shift reservations one slot closer and insert new grants at latency-1.
  // Distinct latencies keep the three insert points apart.
  always_comb begin
    for (int k = 1; k < DIV_LAT; k++) begin
      s_d[k] = s_q[k+1];
    end
    s_d[DIV_LAT] = '0;
    if (gnt_div) begin
      s_d[DIV_LAT-1] = '{v: 1'b1, unit: U_DIV, tag: bus.tag_div};
    end
    if (gnt_mult) begin
      s_d[MULT_LAT-1] = '{v: 1'b1, unit: U_MULT, tag: bus.tag_mult};
    end
  end

  // Next broadcast: slot 1 advances, or a single-cycle int/ld grant fills it.
  always_comb begin
    slot0_d = s_q[1];
    if (gnt_int) begin
      slot0_d = '{v: 1'b1, unit: U_INT, tag: bus.tag_int};
    end else if (gnt_ld) begin
      slot0_d = '{v: 1'b1, unit: U_LD, tag: bus.tag_ld};
    end
    cdb_valid_d = slot0_d.v;
    cdb_sel_d   = 4'b0000;
    if (slot0_d.v) begin
      case (slot0_d.unit)
        U_INT:   cdb_sel_d = 4'b1000;
        U_DIV:   cdb_sel_d = 4'b0100;
        U_MULT:  cdb_sel_d = 4'b0010;
        default: cdb_sel_d = 4'b0001;
      endcase
    end
    cdb_tag_d = slot0_d.v ? slot0_d.tag : cdb_tag_q;
  end

  // Divider occupancy timer: reload on grant, count down to zero.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (gnt_div) begin
      div_cnt_d = DIV_RELOAD;
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
    div_busy_d = (div_cnt_d != '0);
  end

  // State registers; reset discards every in-flight reservation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= DIV_LAT; k++) begin
        s_q[k] <= '0;
      end
      lru_q       <= 1'b0;
      div_cnt_q   <= '0;
      div_busy_q  <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_sel_q   <= 4'b0000;
      cdb_tag_q   <= '0;
    end else begin
      for (int k = 1; k <= DIV_LAT; k++) begin
        s_q[k] <= s_d[k];
      end
      lru_q       <= lru_d;
      div_cnt_q   <= div_cnt_d;
      div_busy_q  <= div_busy_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_sel_q   <= cdb_sel_d;
      cdb_tag_q   <= cdb_tag_d;
    end
  end

  assign bus.gnt_int   = gnt_int;
  assign bus.gnt_ld    = gnt_ld;
  assign bus.gnt_mult  = gnt_mult;
  assign bus.gnt_div   = gnt_div;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_sel   = cdb_sel_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.div_busy  = div_busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with MULT_LAT = 4, DIV_LAT = 7, TAG_W = 6.
// A "cycle" starts 1 time unit after a rising edge (inputs driven there);
// outputs are sampled at the following falling edge.
module tb_cdb_arbiter;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  cdb_arbiter_if #(.TAG_W(6)) bus ();

  cdb_arbiter #(
    .MULT_LAT (4),
    .DIV_LAT  (7),
    .TAG_W    (6)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cdb_chk(input string tag, input logic v, input logic [3:0] sel,
                         input logic [5:0] tg);
    chk({tag, ".valid"}, 32'(bus.cdb_valid), 32'(v));
    chk({tag, ".sel"}, 32'(bus.cdb_sel), 32'(sel));
    if (v) chk({tag, ".tag"}, 32'(bus.cdb_tag), 32'(tg));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    bus.req_int  = 1'b0;
    bus.req_ld   = 1'b0;
    bus.req_mult = 1'b0;
    bus.req_div  = 1'b0;
    bus.tag_int  = '0;
    bus.tag_ld   = '0;
    bus.tag_mult = '0;
    bus.tag_div  = '0;
  endtask

  // Leaves the bench at the start of a fresh cycle 0 with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    clr_inputs();
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b1;
    clr_inputs();
    cyc();

    // ---- reset state; grants forced low while in reset ----
    reset_n = 1'b0;
    bus.req_int = 1'b1;
    bus.req_div = 1'b1;
    sample();
    chk("rst.gnt_int", 32'(bus.gnt_int), 32'd0);
    chk("rst.gnt_div", 32'(bus.gnt_div), 32'd0);
    chk("rst.cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst.cdb_sel", 32'(bus.cdb_sel), 32'd0);
    chk("rst.cdb_tag", 32'(bus.cdb_tag), 32'd0);
    chk("rst.div_busy", 32'(bus.div_busy), 32'd0);

    // ---- isolated int ----
    do_reset();
    bus.req_int = 1'b1;
    bus.tag_int = 6'd5;
    sample();
    chk("int.gnt_c0", 32'(bus.gnt_int), 32'd1);
    cdb_chk("int.c0", 1'b0, 4'b0000, 6'd0);
    cyc();
    clr_inputs();
    sample();
    cdb_chk("int.c1", 1'b1, 4'b1000, 6'd5);
    cyc();
    sample();
    cdb_chk("int.c2", 1'b0, 4'b0000, 6'd0);
    chk("int.tag_hold", 32'(bus.cdb_tag), 32'd5);

    // ---- LRU fairness: int/ld both requesting ----
    do_reset();
    bus.req_int = 1'b1;
    bus.tag_int = 6'd1;
    bus.req_ld  = 1'b1;
    bus.tag_ld  = 6'd2;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("lru.gnt_int_c%0d", i), 32'(bus.gnt_int), 32'((i % 2) == 0));
      chk($sformatf("lru.gnt_ld_c%0d", i), 32'(bus.gnt_ld), 32'((i % 2) == 1));
      if (i > 0) begin
        if (((i - 1) % 2) == 0) cdb_chk($sformatf("lru.cdb_c%0d", i), 1'b1, 4'b1000, 6'd1);
        else                    cdb_chk($sformatf("lru.cdb_c%0d", i), 1'b1, 4'b0001, 6'd2);
      end
      cyc();
    end
    clr_inputs();
    sample();
    cdb_chk("lru.cdb_c4", 1'b1, 4'b0001, 6'd2);
    cyc();
    sample();
    cdb_chk("lru.cdb_c5", 1'b0, 4'b0000, 6'd0);

    // ---- div blocks mult ----
    do_reset();
    bus.req_div = 1'b1;
    bus.tag_div = 6'd9;
    sample();
    chk("dm.gnt_div_c0", 32'(bus.gnt_div), 32'd1);
    cyc();
    clr_inputs();
    cyc();
    cyc();
    bus.req_mult = 1'b1;
    bus.tag_mult = 6'd3;
    sample();
    chk("dm.gnt_mult_c3", 32'(bus.gnt_mult), 32'd0);
    cyc();
    sample();
    chk("dm.gnt_mult_c4", 32'(bus.gnt_mult), 32'd1);
    cyc();
    clr_inputs();
    cyc();
    sample();
    cdb_chk("dm.cdb_c6", 1'b0, 4'b0000, 6'd0);
    cyc();
    sample();
    cdb_chk("dm.cdb_c7", 1'b1, 4'b0100, 6'd9);
    cyc();
    sample();
    cdb_chk("dm.cdb_c8", 1'b1, 4'b0010, 6'd3);
    cyc();
    sample();
    cdb_chk("dm.cdb_c9", 1'b0, 4'b0000, 6'd0);

    // ---- div busy and slot-1 block of int ----
    do_reset();
    bus.req_div = 1'b1;
    bus.tag_div = 6'd10;
    sample();
    chk("db.busy_c0", 32'(bus.div_busy), 32'd0);
    chk("db.gnt_div_c0", 32'(bus.gnt_div), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 6) begin
        bus.req_int = 1'b1;
        bus.tag_int = 6'd7;
      end
      sample();
      chk($sformatf("db.busy_c%0d", c), 32'(bus.div_busy), 32'd1);
      chk($sformatf("db.gnt_div_c%0d", c), 32'(bus.gnt_div), 32'd0);
    end
    chk("db.gnt_int_c6", 32'(bus.gnt_int), 32'd0);
    cyc();
    sample();
    chk("db.busy_c7", 32'(bus.div_busy), 32'd0);
    chk("db.gnt_div_c7", 32'(bus.gnt_div), 32'd1);
    chk("db.gnt_int_c7", 32'(bus.gnt_int), 32'd1);
    cdb_chk("db.cdb_c7", 1'b1, 4'b0100, 6'd10);
    cyc();
    clr_inputs();
    sample();
    cdb_chk("db.cdb_c8", 1'b1, 4'b1000, 6'd7);
    chk("db.busy_c8", 32'(bus.div_busy), 32'd1);

    // ---- same-cycle triple grant ----
    do_reset();
    bus.req_div  = 1'b1;
    bus.tag_div  = 6'd11;
    bus.req_mult = 1'b1;
    bus.tag_mult = 6'd12;
    bus.req_ld   = 1'b1;
    bus.tag_ld   = 6'd13;
    sample();
    chk("tri.gnt_div", 32'(bus.gnt_div), 32'd1);
    chk("tri.gnt_mult", 32'(bus.gnt_mult), 32'd1);
    chk("tri.gnt_ld", 32'(bus.gnt_ld), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 1) clr_inputs();
      sample();
      case (c)
        1:       cdb_chk("tri.cdb_c1", 1'b1, 4'b0001, 6'd13);
        4:       cdb_chk("tri.cdb_c4", 1'b1, 4'b0010, 6'd12);
        7:       cdb_chk("tri.cdb_c7", 1'b1, 4'b0100, 6'd11);
        default: cdb_chk($sformatf("tri.cdb_c%0d", c), 1'b0, 4'b0000, 6'd0);
      endcase
    end

    // ---- reset mid-flight (cdb_tag still holds 11 from the div above) ----
    cyc();
    bus.req_mult = 1'b1;
    bus.tag_mult = 6'd20;
    bus.req_div  = 1'b1;
    bus.tag_div  = 6'd21;
    sample();
    chk("rmf.gnt_mult_c0", 32'(bus.gnt_mult), 32'd1);
    chk("rmf.gnt_div_c0", 32'(bus.gnt_div), 32'd1);
    cyc();
    clr_inputs();
    sample();
    chk("rmf.busy_c1", 32'(bus.div_busy), 32'd1);
    chk("rmf.tag_c1", 32'(bus.cdb_tag), 32'd11);
    cyc();
    reset_n = 1'b0;
    bus.req_mult = 1'b1;
    bus.tag_mult = 6'd22;
    #1;
    chk("rmf.cdb_valid_rst", 32'(bus.cdb_valid), 32'd0);
    chk("rmf.cdb_sel_rst", 32'(bus.cdb_sel), 32'd0);
    chk("rmf.cdb_tag_rst", 32'(bus.cdb_tag), 32'd0);
    chk("rmf.busy_rst", 32'(bus.div_busy), 32'd0);
    chk("rmf.gnt_mult_rst", 32'(bus.gnt_mult), 32'd0);
    cyc();
    reset_n = 1'b1;
    clr_inputs();
    for (int c = 3; c <= 8; c++) begin
      sample();
      chk($sformatf("rmf.valid_c%0d", c), 32'(bus.cdb_valid), 32'd0);
      chk($sformatf("rmf.busy_c%0d", c), 32'(bus.div_busy), 32'd0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback scheduler for the four execution units (integer ALU, load buffer, multiplier, divider) that share the single common data bus (CDB). Each cycle it grants at most one new issue per unit. It reserves the future CDB slot each grant will use, so no two results ever collide. It then drives the registered CDB broadcast controls (valid, unit select, tag) in the cycle each result lands. It sits between the issue queues and the execution units and replaces ad-hoc slot tracking with a single owner-tagged reservation pipeline.

## Interface
Parameters:
- MULT_LAT, 4, multiplier issue-to-CDB latency in cycles; legal range 2..DIV_LAT-1
- DIV_LAT, 7, divider issue-to-CDB latency in cycles; divider is not pipelined
- TAG_W, 6, width of the destination physical register tag

Ports:
- clk  in  1  clock, all state rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req_int, req_ld, req_mult, req_div  in  1 each  unit has a ready instruction this cycle
- tag_int, tag_ld, tag_mult, tag_div  in  TAG_W each  destination tag of the requesting instruction
- gnt_int, gnt_ld, gnt_mult, gnt_div  out  1 each  combinational grant, same cycle as request
- cdb_valid  out  1  registered; a result is broadcast this cycle
- cdb_sel  out  4  registered one-hot {int, div, mult, ld}; selects the result mux
- cdb_tag  out  TAG_W  registered tag being broadcast
- div_busy  out  1  registered; divider occupied, div requests are denied

## Operation
- Latencies: int = 1, ld = 1, mult = MULT_LAT, div = DIV_LAT. A grant in cycle t places the result on the CDB in cycle t+L.
- Reservation array s[1..DIV_LAT]. Each entry is {v, unit[1:0], tag}. During cycle t, s[k] describes the broadcast planned for cycle t+k. The registered outputs are slot 0.
- Every clock edge:
  - s[k] <= s[k+1] for k < DIV_LAT.
  - s[DIV_LAT] <= empty.
  - Slot 0 outputs <= s[1].
  - Grant inserts then override, each writing index L-1: div writes s[DIV_LAT-1], mult writes s[MULT_LAT-1], int/ld write the slot-0 outputs.
- Grant rules, all combinational from current state:
  - gnt_div = req_div & ~div_busy. s[DIV_LAT] is always empty.
  - gnt_mult = req_mult & ~s[MULT_LAT].v.
  - int/ld candidates need ~s[1].v; at most one of the two is granted.
  - Both requesting and slot free: the LRU bit decides. LRU = 0 favours int, LRU = 1 favours ld.
  - LRU toggles only when both request and one is granted; it then points at the loser.
  - A single requester with a free slot is granted regardless of LRU.
- Distinct latencies guarantee that div, mult and int/ld grants in the same cycle never target the same slot. All three may be granted together.
- div_busy: a 3-bit down counter (sized to hold DIV_LAT-1) is loaded with DIV_LAT-1 on gnt_div and decrements to 0. div_busy = (counter != 0).
- Encoding: cdb_sel is zero whenever cdb_valid = 0. cdb_tag holds its previous value when cdb_valid = 0.
- Requesters that are denied hold req and tag; the arbiter keeps no request memory.

## Timing
- Reset (reset_n low, asynchronous): all s[k].v = 0, cdb_valid = 0, cdb_sel = 0, cdb_tag = 0, div counter = 0, div_busy = 0, LRU = 0. Grants are 0 while reset_n is low.
- Reset mid-operation: all in-flight reservations are discarded. No broadcast occurs after release until a new grant.
- Throughput: int or ld can each sustain 1 result per cycle when no long-latency result occupies s[1]. Mult sustains 1 per cycle when its slot is free. Div sustains 1 per DIV_LAT cycles.
- A div grant in cycle t blocks:
  - a mult request in cycle t+DIV_LAT-MULT_LAT;
  - an int/ld request in cycle t+DIV_LAT-1.
- A mult grant in cycle t blocks int/ld in cycle t+MULT_LAT-1.
- Exactly one of cdb_sel is set whenever cdb_valid = 1. cdb_valid is never asserted for two results in the same cycle.

## Test plan
- Isolated int: req_int with tag_int = 5 in cycle 0 -> gnt_int = 1 in cycle 0; in cycle 1 cdb_valid = 1, cdb_sel = 4'b1000, cdb_tag = 5; cdb_valid = 0 in cycle 2.
- LRU fairness: req_int (tag 1) and req_ld (tag 2) held in cycles 0-3, reset state -> grants alternate int, ld, int, ld; CDB shows tags 1, 2, 1, 2 in cycles 1-4; cdb_sel alternates 1000/0001.
- Div blocks mult: gnt_div (tag 9) in cycle 0, req_mult (tag 3) from cycle 3 -> gnt_mult = 0 in cycle 3 and 1 in cycle 4; CDB shows div tag 9 in cycle 7 (sel 0100) and mult tag 3 in cycle 8 (sel 0010).
- Div busy and slot block: gnt_div in cycle 0, req_div held -> div_busy = 1 in cycles 1-6, next gnt_div in cycle 7; req_int in cycle 6 denied, granted in cycle 7, broadcast in cycle 8.
- Same-cycle triple grant: req_div, req_mult, req_ld in cycle 0 with all slots free -> all three granted; broadcasts: ld in cycle 1, mult in cycle 4, div in cycle 7; no cycle has two results.
- Reset mid-flight: gnt_mult in cycle 0, reset_n low in cycle 2 and high in cycle 3 -> all outputs 0 immediately; no cdb_valid in cycles 3-6; div_busy = 0.
